// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin, packet-locked arbiter feeding one UART transmitter from P_NUM_REQ word sources.
// Latency: one cycle from accepted requester word to tx_word; one idle arbitration cycle between grants.
// Backpressure: tx_word_rdy low holds the output register and deasserts req_rdy of the granted requester.
module uart_tx_arbiter #(
  parameter int P_NUM_REQ   = 4,
  parameter int P_NUM_BITS  = 8,
  parameter int P_MAX_BURST = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [P_NUM_REQ*P_NUM_BITS-1:0]   req_word,
  input  logic [P_NUM_REQ-1:0]              req_vld,
  input  logic [P_NUM_REQ-1:0]              req_last,
  output logic [P_NUM_REQ-1:0]              req_rdy,
  output logic [P_NUM_BITS-1:0]             tx_word,
  output logic                              tx_word_vld,
  input  logic                              tx_word_rdy,
  output logic [$clog2(P_NUM_REQ)-1:0]      grant_id,
  output logic                              busy
);

  localparam int              P_ID_W      = $clog2(P_NUM_REQ);
  localparam logic [7:0]      L_MAX_BURST = 8'(P_MAX_BURST);
  localparam logic [P_ID_W-1:0] L_LAST_ID = P_ID_W'(P_NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [P_ID_W-1:0]   rr_ptr_q;
  logic [7:0]          burst_cnt_q;

  logic [P_NUM_BITS-1:0] cur_word;
  logic                  cur_vld;
  logic                  cur_last;
  logic                  arb_found;
  logic [P_ID_W-1:0]     arb_id;
  logic                  out_free;
  logic                  xfer;
  logic                  release_grant;
  logic [7:0]            burst_nxt;
  logic [P_ID_W-1:0]     next_ptr;

  // Select the granted requester's word, valid and last flag.
  always_comb begin
    cur_word = '0;
    cur_vld  = 1'b0;
    cur_last = 1'b0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (grant_id == P_ID_W'(i)) begin
        cur_word = req_word[i*P_NUM_BITS +: P_NUM_BITS];
        cur_vld  = req_vld[i];
        cur_last = req_last[i];
      end
    end
  end

  // Round-robin pick: first valid at or above rr_ptr, else lowest valid (wrap).
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (!arb_found && req_vld[i] && (P_ID_W'(i) >= rr_ptr_q)) begin
        arb_found = 1'b1;
        arb_id    = P_ID_W'(i);
      end
    end
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (!arb_found && req_vld[i]) begin
        arb_found = 1'b1;
        arb_id    = P_ID_W'(i);
      end
    end
  end

  // The output stage can take a word when empty or draining this cycle.
  assign out_free      = ~tx_word_vld | tx_word_rdy;
  assign xfer          = (state_q == S_GRANT) & cur_vld & out_free;
  assign burst_nxt     = burst_cnt_q + 8'd1;
  assign release_grant = xfer & (cur_last | (burst_nxt == L_MAX_BURST));
  assign next_ptr      = (grant_id == L_LAST_ID) ? '0 : grant_id + 1'b1;
  assign busy          = (state_q == S_GRANT) | tx_word_vld;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-requester ready; idle cycles are the arbitration bubble.
  always_comb begin
    state_d = state_q;
    req_rdy = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        for (int i = 0; i < P_NUM_REQ; i++) begin
          if (grant_id == P_ID_W'(i)) begin
            req_rdy[i] = out_free;
          end
        end
        if (release_grant) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant bookkeeping: load winner on arbitration, count burst, advance pointer on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (arb_found) begin
        grant_id    <= arb_id;
        burst_cnt_q <= '0;
      end
    end else if (xfer) begin
      burst_cnt_q <= burst_nxt;
      if (release_grant) begin
        rr_ptr_q <= next_ptr;
      end
    end
  end

  // Single output stage: load on transfer (replacing a draining word), clear on drain otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word     <= '0;
      tx_word_vld <= 1'b0;
    end else if (xfer) begin
      tx_word     <= cur_word;
      tx_word_vld <= 1'b1;
    end else if (tx_word_rdy) begin
      tx_word_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit words, burst cap 4).
// Latency: checks one-cycle word latency and one idle cycle between grants.
// Backpressure: drives tx_word_rdy low for a stretch and checks the held word and zero req_rdy.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_word;
  logic [3:0]  req_vld;
  logic [3:0]  req_last;
  logic [3:0]  req_rdy;
  logic [7:0]  tx_word;
  logic        tx_word_vld;
  logic        tx_word_rdy;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(
    .P_NUM_REQ  (4),
    .P_NUM_BITS (8),
    .P_MAX_BURST(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_word   (req_word),
    .req_vld    (req_vld),
    .req_last   (req_last),
    .req_rdy    (req_rdy),
    .tx_word    (tx_word),
    .tx_word_vld(tx_word_vld),
    .tx_word_rdy(tx_word_rdy),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Requester model: per-requester list of {gap[6:0], last, word}; gap = idle cycles before the word.
  logic [15:0] rq [4][16];
  int          rh [4];
  int          rt [4];
  logic        tx_rdy_set;

  int in_word [$];
  int in_cyc  [$];
  int out_word[$];
  int out_cyc [$];
  int ev [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] w, input logic l, input logic [6:0] gap);
    rq[i][rt[i]] = {gap, l, w};
    rt[i]++;
  endtask

  task automatic clear_logs();
    in_word.delete();
    in_cyc.delete();
    out_word.delete();
    out_cyc.delete();
  endtask

  // Drive inputs at the falling edge, then record handshakes that the next rising edge will take.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      logic [15:0] e;
      @(negedge clk);
      cyc++;
      tx_word_rdy = tx_rdy_set;
      for (int i = 0; i < 4; i++) begin
        req_vld[i]  = 1'b0;
        req_last[i] = 1'b0;
        req_word[i*8 +: 8] = 8'h00;
        if (rh[i] != rt[i]) begin
          e = rq[i][rh[i]];
          if (e[15:9] != 7'd0) begin
            rq[i][rh[i]] = e - 16'h0200;
          end else begin
            req_vld[i]  = 1'b1;
            req_last[i] = e[8];
            req_word[i*8 +: 8] = e[7:0];
          end
        end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          in_word.push_back(int'(req_word[i*8 +: 8]));
          in_cyc.push_back(cyc);
          rh[i]++;
        end
      end
      if (tx_word_vld && tx_word_rdy) begin
        out_word.push_back(int'(tx_word));
        out_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic check_out(input string tag, input int n);
    check({tag, "_count"}, out_word.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < out_word.size()) check(tag, out_word[i], ev[i]);
      else check(tag, 32'hFFFF_FFFF, ev[i]);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_vld     = '0;
    req_last    = '0;
    req_word    = '0;
    tx_rdy_set  = 1'b1;
    tx_word_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rh[i] = 0;
      rt[i] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx_vld", tx_word_vld, 0);
    check("rst_tx_word", tx_word, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    int c0;
    int bad;
    rst_n = 1'b1;
    #2;
    do_reset();

    // Single requester, three-word packet.
    push(2, 8'h11, 1'b0, 7'd0);
    push(2, 8'h22, 1'b0, 7'd0);
    push(2, 8'h33, 1'b1, 7'd0);
    c0 = cyc + 1;
    run(6);
    ev = '{8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0};
    check_out("single_word", 3);
    if (out_cyc.size() > 0) check("single_first_latency", out_cyc[0] - c0, 2);
    if (out_cyc.size() > 2) check("single_back_to_back", out_cyc[2] - out_cyc[0], 2);
    check("single_grant_hold", grant_id, 2);
    check("single_idle_busy", busy, 0);

    // Pointer now at 3: with 1 and 3 valid, 3 wins first.
    clear_logs();
    push(1, 8'h61, 1'b1, 7'd0);
    push(3, 8'h63, 1'b1, 7'd0);
    run(6);
    ev = '{8'h63, 8'h61, 0, 0, 0, 0, 0, 0};
    check_out("rr_ptr_after_2", 2);

    // Round robin with continuous one-word packets.
    do_reset();
    for (int k = 0; k < 4; k++) push(k, 8'(k), 1'b1, 7'd0);
    for (int k = 0; k < 4; k++) push(k, 8'(8'h10 + k), 1'b1, 7'd0);
    run(18);
    ev = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};
    check_out("rr_order", 8);
    bad = 0;
    for (int i = 0; i + 1 < in_cyc.size(); i++) if (in_cyc[i+1] - in_cyc[i] != 2) bad++;
    check("rr_one_idle_gap", bad, 0);

    // Packet lock: requester 0 pauses mid-packet while 1 waits.
    do_reset();
    push(0, 8'hA0, 1'b0, 7'd0);
    push(0, 8'hA1, 1'b1, 7'd5);
    push(1, 8'hB1, 1'b1, 7'd0);
    run(4);
    check("lock_req_rdy", req_rdy, 4'b0001);
    check("lock_grant_id", grant_id, 0);
    check("lock_busy", busy, 1);
    run(10);
    ev = '{8'hA0, 8'hA1, 8'hB1, 0, 0, 0, 0, 0};
    check_out("lock_order", 3);

    // Burst cap of 4 words forces a hand-off to requester 3.
    do_reset();
    for (int k = 0; k < 6; k++) push(1, 8'(8'hC0 + k), 1'b0, 7'd0);
    push(3, 8'hD0, 1'b1, 7'd0);
    run(14);
    ev = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hC4, 8'hC5, 0};
    check_out("burst_cap", 7);

    // Backpressure: held word must not change or be lost.
    do_reset();
    push(0, 8'h5A, 1'b1, 7'd0);
    push(0, 8'h5B, 1'b1, 7'd0);
    push(2, 8'h7E, 1'b1, 7'd0);
    tx_rdy_set = 1'b0;
    run(12);
    check("bp_tx_word", tx_word, 8'h5A);
    check("bp_tx_vld", tx_word_vld, 1);
    check("bp_req_rdy", req_rdy, 0);
    check("bp_grant_id", grant_id, 2);
    check("bp_busy", busy, 1);
    tx_rdy_set = 1'b1;
    run(8);
    ev = '{8'h5A, 8'h7E, 8'h5B, 0, 0, 0, 0, 0};
    check_out("bp_drain", 3);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    push(2, 8'h21, 1'b1, 7'd0);
    run(5);
    push(1, 8'hE0, 1'b0, 7'd0);
    push(1, 8'hE1, 1'b0, 7'd0);
    push(1, 8'hE2, 1'b0, 7'd0);
    run(3);
    check("pre_arst_tx_vld", tx_word_vld, 1);
    check("pre_arst_req_rdy", req_rdy, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_vld", tx_word_vld, 0);
    check("arst_req_rdy", req_rdy, 0);
    check("arst_busy", busy, 0);
    check("arst_tx_word", tx_word, 0);
    do_reset();
    push(1, 8'h31, 1'b1, 7'd0);
    push(3, 8'h33, 1'b1, 7'd0);
    run(6);
    ev = '{8'h31, 8'h33, 0, 0, 0, 0, 0, 0};
    check_out("post_arst_order", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter P_NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter P_NUM_BITS, default 8, word width.
REQ-003 SHALL have parameter P_MAX_BURST, default 16, max words per grant (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_word  input  P_NUM_REQ*P_NUM_BITS  packed words; requester i at bits [i*P_NUM_BITS +: P_NUM_BITS].
REQ-007 SHALL have port req_vld  input  P_NUM_REQ  per-requester word valid.
REQ-008 SHALL have port req_last  input  P_NUM_REQ  per-requester last-word-of-packet flag, qualified by req_vld.
REQ-009 SHALL have port req_rdy  output  P_NUM_REQ  per-requester ready.
REQ-010 SHALL have port tx_word  output  P_NUM_BITS  word to UART transmitter.
REQ-011 SHALL have port tx_word_vld  output  1  tx_word valid.
REQ-012 SHALL have port tx_word_rdy  input  1  transmitter accepts word.
REQ-013 SHALL have port grant_id  output  clog2(P_NUM_REQ)  index of current/last granted requester.
REQ-014 SHALL have port busy  output  1  high while in S_GRANT or tx_word_vld high.

Function
REQ-015 SHALL implement states S_IDLE, S_GRANT.
REQ-016 In S_IDLE, if any req_vld set, SHALL select the first set bit scanning from rr_ptr upward with wrap, load grant_id, clear burst counter, go to S_GRANT next cycle; otherwise stay.
REQ-017 In S_IDLE, req_rdy SHALL be all zeros (one-cycle arbitration bubble).
REQ-018 In S_GRANT, req_rdy[grant_id] SHALL equal (~tx_word_vld | tx_word_rdy); all other bits zero.
REQ-019 A word transfers from requester when req_vld[grant_id] & req_rdy[grant_id]; it SHALL appear on tx_word with tx_word_vld=1 on the next cycle (latency 1).
REQ-020 tx_word/tx_word_vld SHALL be a single registered stage; tx_word_vld clears when tx_word_rdy=1 and no new word loads the same cycle.
REQ-021 Simultaneous drain and load SHALL replace tx_word with no bubble (full throughput 1 word/cycle).
REQ-022 tx_word and tx_word_vld SHALL be stable while tx_word_vld=1 and tx_word_rdy=0.
REQ-023 Burst counter (8 bits) SHALL increment per transferred word in S_GRANT.
REQ-024 Grant SHALL release (go S_IDLE, rr_ptr <= (grant_id+1) mod P_NUM_REQ) on transfer of a word with req_last set, or when that transfer makes burst count equal P_MAX_BURST, whichever first.
REQ-025 Granted requester dropping req_vld without last SHALL NOT release grant (packet lock), except by P_MAX_BURST.
REQ-026 Words of one grant SHALL be forwarded in order, never interleaved with another requester.
REQ-027 Requesters not granted SHALL see req_rdy=0 regardless of their req_vld.
REQ-028 grant_id SHALL hold its value in S_IDLE until the next arbitration.
REQ-029 Output register drain SHALL proceed independently of state (including across the release cycle).

Reset
REQ-030 On rst_n low, asynchronously: state=S_IDLE, rr_ptr=0, grant_id=0, burst count=0, tx_word=0, tx_word_vld=0; hence req_rdy=0, busy=0.
REQ-031 Reset mid-packet SHALL discard the held word and partial grant; after release, arbitration restarts from requester 0.

Verification
REQ-032 Single requester: req 2 sends 0x11,0x22,0x33(last), tx_word_rdy=1 -> tx sees 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after req_vld, grant_id=2, then S_IDLE, rr_ptr=3.
REQ-033 Round robin: all 4 requesters send 1-word packets continuously -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-034 Packet lock: req 0 sends 0xA0, drops req_vld 5 cycles, sends 0xA1(last) while req 1 valid -> tx order 0xA0,0xA1, then req 1.
REQ-035 Burst cap: P_MAX_BURST=4, req 1 streams 6 words no last, req 3 valid -> 4 words from req 1, then req 3 granted, then req 1 resumes.
REQ-036 Backpressure: tx_word_rdy=0 for 10 cycles with word 0x5A held -> tx_word stays 0x5A, req_rdy all zero, no word lost after tx_word_rdy returns.
REQ-037 Async reset asserted mid-packet (between clk edges) -> tx_word_vld, req_rdy, busy drop immediately; first grant after reset goes to lowest valid index.
